// File: rtl/scc_dump_pkg.sv
// -----------------------------------------------------------------------------
// scc_dump_pkg
// Shared definitions for the SCC post-halt memory dump engine.
//   state_e        : dump FSM state encoding
//   HDR_ERR_W      : width of the core error code carried in the header record
//   DATA_W         : data-memory word width
//   DEF_ADDR_STEP  : default byte-address increment between consecutive words
// -----------------------------------------------------------------------------
package scc_dump_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_RD   = 3'd2,
      ST_WT   = 3'd3,
      ST_EM   = 3'd4,
      ST_FIN  = 3'd5
   } state_e;

   localparam int          HDR_ERR_W     = 2;
   localparam int          DATA_W        = 32;
   localparam logic [31:0] DEF_ADDR_STEP = 32'd4;

endpackage

// File: rtl/scc_mem_dump.sv
// -----------------------------------------------------------------------------
// scc_mem_dump
// Post-halt memory dump engine. On the 0->1 edge of halt_f (seen in IDLE) it
// emits one header record, then walks data memory through a synchronous read
// port and emits one (byte address, word) record per word on a valid/ready
// stream.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   clk_en         : global clock enable; all state holds while low
//   halt_f         : core halted flag (level)
//   err_bits       : core error code, captured when a dump starts
//   mem_rd_en      : data-memory read strobe (one enabled cycle per word)
//   mem_rd_idx     : word index being read
//   mem_rd_data    : read data, valid one enabled cycle after mem_rd_en
//   out_valid      : record valid
//   out_ready      : sink ready
//   out_hdr        : record is the header
//   out_addr       : byte address (header: DEPTH_WORDS)
//   out_data       : word value   (header: captured err_bits, zero-extended)
//   out_last       : final data record
//   busy           : dump in progress
//   done           : dump complete, held until halt_f drops
// -----------------------------------------------------------------------------
module scc_mem_dump
   import scc_dump_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] ADDR_STEP   = DEF_ADDR_STEP,
   parameter int unsigned AW          = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 halt_f,
   input  logic [HDR_ERR_W-1:0] err_bits,
   output logic                 mem_rd_en,
   output logic [AW-1:0]        mem_rd_idx,
   input  logic [DATA_W-1:0]    mem_rd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_hdr,
   output logic [31:0]          out_addr,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

   state_e              state_q, state_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic                halt_q;
   logic [31:0]         addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (halt_f && !halt_q) begin
               state_d = ST_HDR;
               idx_d   = '0;
               addr_d  = 32'(DEPTH_WORDS);
               data_d  = {{(DATA_W-HDR_ERR_W){1'b0}}, err_bits};
            end
         end
         ST_HDR: begin
            if (out_ready) state_d = ST_RD;
         end
         ST_RD: begin
            state_d = ST_WT;
         end
         ST_WT: begin
            // Read data is valid in this cycle; the address product wraps mod 2^32.
            data_d  = mem_rd_data;
            addr_d  = BASE_ADDR + 32'(idx_q) * ADDR_STEP;
            state_d = ST_EM;
         end
         ST_EM: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_FIN;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_RD;
               end
            end
         end
         ST_FIN: begin
            if (!halt_f) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         halt_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (clk_en) begin
         state_q <= state_d;
         idx_q   <= idx_d;
         halt_q  <= halt_f;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign out_valid  = (state_q == ST_HDR) || (state_q == ST_EM);
   assign out_hdr    = (state_q == ST_HDR);
   assign out_addr   = addr_q;
   assign out_data   = data_q;
   // Only data records can be last, so a one-word dump still has a plain header.
   assign out_last   = (state_q == ST_EM) && (idx_q == LAST_IDX);
   assign busy       = (state_q == ST_HDR) || (state_q == ST_RD) ||
                       (state_q == ST_WT)  || (state_q == ST_EM);
   assign done       = (state_q == ST_FIN);
   // Gated so a stalled clock never issues a read that nobody will capture.
   assign mem_rd_en  = clk_en && (state_q == ST_RD);
   assign mem_rd_idx = idx_q;

endmodule
